// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared constants for the 7-segment scan controller:
//   SEG_OFF  - all segments dark (active-low pattern)
//   HEX_SEG  - nibble-to-segment lookup, bit order {g,f,e,d,c,b,a}, active-low
//   scan_state_e - scan FSM states (BLANK gap, SHOW digit)
// -----------------------------------------------------------------------------
package seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
    7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
    7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
    7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
  };

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_e;

endpackage

// File: rtl/seg_scan_ctrl_hex7seg.sv
// -----------------------------------------------------------------------------
// hex7seg
// Purely combinational hex nibble to 7-segment decoder (active-low segments).
// Ports:
//   nibble_i  4-bit hex digit
//   seg_o     segments {g,f,e,d,c,b,a}, 0 = lit
// -----------------------------------------------------------------------------
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG[nibble_i];

endmodule

// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
// Time-multiplexed driver for a common-anode multi-digit 7-segment display.
// A value arrives over a valid/ready handshake into a pending buffer and is
// promoted to the display registers only at a frame boundary (or at once while
// scanning is disabled), so a frame never shows a mix of two values.
// Each digit is preceded by an all-off blanking gap to suppress ghosting.
// Ports:
//   clk         system clock
//   reset       asynchronous reset, active-low
//   en          scan enable; low blanks the display and restarts the scan
//   val_data    value, hex digit 0 is the rightmost
//   val_dp      decimal point per digit, 1 = lit
//   val_lz      1 = suppress leading zeros
//   val_valid   new value offered
//   val_ready   controller can accept a value
//   seg         segments {g,f,e,d,c,b,a}, active-low, registered
//   an          anodes, active-low, registered
//   dp          decimal point, active-low, registered
//   frame_done  one-cycle pulse during the last cycle of a full scan
// -----------------------------------------------------------------------------
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int DWELL_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [4*N_DIGITS-1:0] val_data,
  input  logic [N_DIGITS-1:0]   val_dp,
  input  logic                  val_lz,
  input  logic                  val_valid,
  output logic                  val_ready,
  output logic [6:0]            seg,
  output logic [N_DIGITS-1:0]   an,
  output logic                  dp,
  output logic                  frame_done
);

  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int DIG_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [DIG_W-1:0] DIG_LAST   = DIG_W'(N_DIGITS - 1);

  scan_state_e             state_q, state_d;
  logic [DIG_W-1:0]        digit_q, digit_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    frameEnd;

  logic [4*N_DIGITS-1:0]   dispData_q, dispData_d;
  logic [N_DIGITS-1:0]     dispDp_q, dispDp_d;
  logic                    dispLz_q, dispLz_d;
  logic [4*N_DIGITS-1:0]   pendData_q, pendData_d;
  logic [N_DIGITS-1:0]     pendDp_q, pendDp_d;
  logic                    pendLz_q, pendLz_d;
  logic                    pending_q, pending_d;

  logic [6:0]              seg_q, seg_d;
  logic [N_DIGITS-1:0]     an_q, an_d;
  logic                    dp_q, dp_d;

  logic [3:0]              curNibble;
  logic                    curDp;
  logic                    suppress;
  logic [6:0]              decSeg;
  logic                    transfer;
  logic                    commit;

  // Scan sequencing. Dropping en parks the scan at the start of digit 0's
  // blanking gap; frame end is the last cycle of the last digit's dwell.
  always_comb begin
    state_d  = state_q;
    digit_d  = digit_q;
    cnt_d    = cnt_q + CNT_W'(1);
    frameEnd = 1'b0;
    if (!en) begin
      state_d = BLANK;
      digit_d = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = SHOW;
            cnt_d   = '0;
          end
        end
        SHOW: begin
          if (cnt_q == DWELL_LAST) begin
            state_d = BLANK;
            cnt_d   = '0;
            if (digit_q == DIG_LAST) begin
              digit_d  = '0;
              frameEnd = 1'b1;
            end else begin
              digit_d = digit_q + DIG_W'(1);
            end
          end
        end
        default: begin
          state_d = BLANK;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Select the current digit's nibble and dp bit, and decide leading-zero
  // blanking: digit k>0 goes dark when it and every digit above it are zero.
  always_comb begin
    curNibble = 4'h0;
    curDp     = 1'b0;
    suppress  = dispLz_q && (digit_q != '0);
    for (int k = 0; k < N_DIGITS; k++) begin
      if (DIG_W'(k) == digit_q) begin
        curNibble = dispData_q[4*k +: 4];
        curDp     = dispDp_q[k];
      end
      if ((DIG_W'(k) >= digit_q) && (dispData_q[4*k +: 4] != 4'h0)) begin
        suppress = 1'b0;
      end
    end
  end

  hex7seg uDecode (
    .nibble_i (curNibble),
    .seg_o    (decSeg)
  );

  // Next pin values; en low blanks the pins on the very next cycle.
  always_comb begin
    seg_d = SEG_OFF;
    an_d  = '1;
    dp_d  = 1'b1;
    if (en && (state_q == SHOW)) begin
      for (int k = 0; k < N_DIGITS; k++) begin
        if (DIG_W'(k) == digit_q) begin
          an_d[k] = 1'b0;
        end
      end
      seg_d = suppress ? SEG_OFF : decSeg;
      dp_d  = ~curDp;
    end
  end

  // Handshake buffer. A transfer can only land when nothing is pending, so a
  // commit and a transfer in the same cycle never contend: the commit finds
  // the buffer empty and the new value waits for the next frame end.
  assign transfer = val_valid && !pending_q;
  assign commit   = frameEnd || !en;

  always_comb begin
    dispData_d = dispData_q;
    dispDp_d   = dispDp_q;
    dispLz_d   = dispLz_q;
    pendData_d = pendData_q;
    pendDp_d   = pendDp_q;
    pendLz_d   = pendLz_q;
    pending_d  = pending_q;
    if (commit && pending_q) begin
      dispData_d = pendData_q;
      dispDp_d   = pendDp_q;
      dispLz_d   = pendLz_q;
      pending_d  = 1'b0;
    end
    if (transfer) begin
      pendData_d = val_data;
      pendDp_d   = val_dp;
      pendLz_d   = val_lz;
      pending_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= BLANK;
      digit_q    <= '0;
      cnt_q      <= '0;
      dispData_q <= '0;
      dispDp_q   <= '0;
      dispLz_q   <= 1'b0;
      pendData_q <= '0;
      pendDp_q   <= '0;
      pendLz_q   <= 1'b0;
      pending_q  <= 1'b0;
      seg_q      <= SEG_OFF;
      an_q       <= '1;
      dp_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      digit_q    <= digit_d;
      cnt_q      <= cnt_d;
      dispData_q <= dispData_d;
      dispDp_q   <= dispDp_d;
      dispLz_q   <= dispLz_d;
      pendData_q <= pendData_d;
      pendDp_q   <= pendDp_d;
      pendLz_q   <= pendLz_d;
      pending_q  <= pending_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
      dp_q       <= dp_d;
    end
  end

  assign val_ready  = ~pending_q;
  assign seg        = seg_q;
  assign an         = an_q;
  assign dp         = dp_q;
  assign frame_done = frameEnd;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_ctrl
// Self-checking bench for seg_scan_ctrl with a short scan (4 digits, 8-cycle
// dwell, 2-cycle blank, 40-cycle frame). The reference model tracks position
// within the frame arithmetically plus a pending/display value pair.
// -----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

  localparam int ND    = 4;
  localparam int DWELL = 8;
  localparam int BLNK  = 2;
  localparam int SLOT  = DWELL + BLNK;
  localparam int FRAME = ND * SLOT;

  localparam logic [6:0] DEC [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic          clk;
  logic          reset;
  logic          en;
  logic [15:0]   val_data;
  logic [3:0]    val_dp;
  logic          val_lz;
  logic          val_valid;
  logic          val_ready;
  logic [6:0]    seg;
  logic [3:0]    an;
  logic          dp;
  logic          frame_done;

  int vectors;
  int miscompares;

  // Reference model state
  int            mPos;
  logic [15:0]   mDisp;
  logic [3:0]    mDispDp;
  logic          mDispLz;
  logic [15:0]   mPend;
  logic [3:0]    mPendDp;
  logic          mPendLz;
  logic          mPending;
  logic [6:0]    mSeg;
  logic [3:0]    mAn;
  logic          mDp;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dpIn;
    logic        lz;
    logic [6:0]  expSeg [4];
    logic [3:0]  expDp;
  } vec_t;

  seg_scan_ctrl #(
    .N_DIGITS     (ND),
    .DWELL_CYCLES (DWELL),
    .BLANK_CYCLES (BLNK)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .val_data   (val_data),
    .val_dp     (val_dp),
    .val_lz     (val_lz),
    .val_valid  (val_valid),
    .val_ready  (val_ready),
    .seg        (seg),
    .an         (an),
    .dp         (dp),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic modelReset();
    mPos     = 0;
    mDisp    = '0;
    mDispDp  = '0;
    mDispLz  = 1'b0;
    mPend    = '0;
    mPendDp  = '0;
    mPendLz  = 1'b0;
    mPending = 1'b0;
    mSeg     = 7'h7F;
    mAn      = 4'hF;
    mDp      = 1'b1;
  endtask

  // What the pins should show for frame position pos with the current display value.
  task automatic modelView(input int pos);
    int q;
    int d;
    logic [15:0] upper;
    logic [3:0] nib;
    q = pos % FRAME;
    d = q / SLOT;
    if ((q % SLOT) < BLNK) begin
      mSeg = 7'h7F;
      mAn  = 4'hF;
      mDp  = 1'b1;
    end else begin
      upper = mDisp >> (4 * d);
      nib   = upper[3:0];
      mAn   = ~(4'b0001 << d);
      mDp   = ~mDispDp[d];
      mSeg  = (mDispLz && (d > 0) && (upper == 16'h0)) ? 7'h7F : DEC[nib];
    end
  endtask

  // Applies one clock edge worth of specification rules to the model.
  task automatic modelEdge();
    bit frameEnd;
    bit xfer;
    frameEnd = en && ((mPos % FRAME) == FRAME - 1);
    xfer     = val_valid && !mPending;
    if (en) begin
      modelView(mPos);
    end else begin
      mSeg = 7'h7F;
      mAn  = 4'hF;
      mDp  = 1'b1;
    end
    if ((frameEnd || !en) && mPending) begin
      mDisp    = mPend;
      mDispDp  = mPendDp;
      mDispLz  = mPendLz;
      mPending = 1'b0;
    end
    if (xfer) begin
      mPend    = val_data;
      mPendDp  = val_dp;
      mPendLz  = val_lz;
      mPending = 1'b1;
    end
    mPos = en ? mPos + 1 : 0;
  endtask

  // One clock: frame_done checked before the edge, registered pins after it.
  task automatic applyStimulus();
    #1;
    checkOutput("frame_done", 32'(frame_done), 32'(en && ((mPos % FRAME) == FRAME - 1)));
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput("seg", 32'(seg), 32'(mSeg));
    checkOutput("an", 32'(an), 32'(mAn));
    checkOutput("dp", 32'(dp), 32'(mDp));
    checkOutput("val_ready", 32'(val_ready), 32'(!mPending));
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic offer(input logic [15:0] d, input logic [3:0] p, input logic l);
    val_valid = 1'b1;
    val_data  = d;
    val_dp    = p;
    val_lz    = l;
  endtask

  vec_t vecs [7];

  initial begin
    logic [6:0] segCap [4];
    logic [3:0] dpCap;
    bit found;

    vecs[0] = '{16'h12AF, 4'b0100, 1'b0, '{7'h0E, 7'h08, 7'h24, 7'h79}, 4'b1011};
    vecs[1] = '{16'h0030, 4'b0000, 1'b1, '{7'h40, 7'h30, 7'h7F, 7'h7F}, 4'b1111};
    vecs[2] = '{16'h0000, 4'b0000, 1'b1, '{7'h40, 7'h7F, 7'h7F, 7'h7F}, 4'b1111};
    vecs[3] = '{16'h0000, 4'b0000, 1'b0, '{7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111};
    vecs[4] = '{16'h8001, 4'b1001, 1'b1, '{7'h79, 7'h40, 7'h40, 7'h00}, 4'b0110};
    vecs[5] = '{16'hBEEF, 4'b0000, 1'b0, '{7'h0E, 7'h06, 7'h06, 7'h03}, 4'b1111};
    vecs[6] = '{16'h0C05, 4'b0010, 1'b1, '{7'h12, 7'h40, 7'h46, 7'h7F}, 4'b1101};

    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    en          = 1'b1;
    val_valid   = 1'b0;
    val_data    = '0;
    val_dp      = '0;
    val_lz      = 1'b0;
    modelReset();

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    checkOutput("rst_seg", 32'(seg), 32'h7F);
    checkOutput("rst_an", 32'(an), 32'hF);
    checkOutput("rst_dp", 32'(dp), 32'h1);
    checkOutput("rst_ready", 32'(val_ready), 32'h1);
    checkOutput("rst_frame_done", 32'(frame_done), 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Idle scan of "0000": digit 0 lit after blank gap, two full frames
    runCycles(3);
    checkOutput("first_an", 32'(an), 32'hE);
    checkOutput("first_seg", 32'(seg), 32'h40);
    runCycles(2 * FRAME - 3);

    // Mid-frame transfer: ready drops, display holds until frame end
    runCycles(15);
    offer(16'h12AF, 4'b0100, 1'b0);
    applyStimulus();
    val_valid = 1'b0;
    checkOutput("ready_low", 32'(val_ready), 32'h0);
    runCycles(2 * FRAME);

    // Leading-zero value
    offer(16'h0030, 4'b0000, 1'b1);
    applyStimulus();
    val_valid = 1'b0;
    runCycles(2 * FRAME);

    // Second offer held while pending: no capture until ready returns
    runCycles(7);
    offer(16'h4567, 4'b0001, 1'b0);
    applyStimulus();
    offer(16'h9ABC, 4'b1000, 1'b0);
    runCycles(FRAME + 5);
    val_valid = 1'b0;
    runCycles(2 * FRAME);

    // en dropped in the middle of digit 2's dwell
    found = 1'b0;
    for (int i = 0; i < FRAME && !found; i++) begin
      if ((mPos % FRAME) == 2 * SLOT + 5) found = 1'b1;
      else applyStimulus();
    end
    checkOutput("align_digit2", 32'(found), 32'h1);
    en = 1'b0;
    offer(16'hBEEF, 4'b0000, 1'b0);
    applyStimulus();
    val_valid = 1'b0;
    checkOutput("en_low_an", 32'(an), 32'hF);
    applyStimulus();
    checkOutput("en_low_commit", 32'(val_ready), 32'h1);
    en = 1'b1;
    runCycles(3);
    checkOutput("resume_an", 32'(an), 32'hE);
    checkOutput("resume_seg", 32'(seg), 32'h0E);
    runCycles(FRAME);

    // Table-driven frames: load each value with scan disabled, then scan once
    for (int v = 0; v < 7; v++) begin
      en        = 1'b0;
      val_valid = 1'b0;
      runCycles(2);
      offer(vecs[v].data, vecs[v].dpIn, vecs[v].lz);
      applyStimulus();
      val_valid = 1'b0;
      applyStimulus();
      en = 1'b1;
      for (int k = 0; k < 4; k++) segCap[k] = 'x;
      dpCap = 'x;
      for (int c = 0; c <= FRAME; c++) begin
        applyStimulus();
        for (int k = 0; k < 4; k++) begin
          if (an == ~(4'b0001 << k)) begin
            segCap[k] = seg;
            dpCap[k]  = dp;
          end
        end
      end
      for (int k = 0; k < 4; k++)
        checkOutput($sformatf("tbl%0d_seg%0d", v, k), 32'(segCap[k]), 32'(vecs[v].expSeg[k]));
      checkOutput($sformatf("tbl%0d_dp", v), 32'(dpCap), 32'(vecs[v].expDp));
    end

    // Reset pulse mid-frame with a value pending
    runCycles(13);
    offer(16'h7777, 4'b1111, 1'b0);
    applyStimulus();
    val_valid = 1'b0;
    runCycles(4);
    #2 reset = 1'b0;
    #1;
    checkOutput("async_seg", 32'(seg), 32'h7F);
    checkOutput("async_an", 32'(an), 32'hF);
    checkOutput("async_dp", 32'(dp), 32'h1);
    checkOutput("async_ready", 32'(val_ready), 32'h1);
    @(posedge clk);
    #1 reset = 1'b1;
    modelReset();
    runCycles(3);
    checkOutput("post_rst_seg", 32'(seg), 32'h40);
    runCycles(2 * FRAME);

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      if (en) begin
        if ($urandom_range(63) == 0) en = 1'b0;
      end else if ($urandom_range(3) == 0) begin
        en = 1'b1;
      end
      if ($urandom_range(3) == 0) begin
        offer(16'($urandom) & (16'hFFFF >> (4 * $urandom_range(3))),
              4'($urandom), 1'($urandom));
      end else begin
        val_valid = 1'b0;
      end
      applyStimulus();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
